rgb_pwm_driver: RTL and testbench

Converts the 8-bit R, G and B levels produced by the light control unit into three PWM pin drives for a physical RGB LED. It sits directly downstream of `controlunit` and consumes its `r`, `g` and `b` outputs. Duty values are double-buffered: new levels take effect only at a frame boundary, so mid-frame changes never cause glitches. The block also flags each frame start so other logic can align to it.

---
 rtl/rgb_pwm_driver.sv | 94 +++++++++
 tb/tb_rgb_pwm_driver.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM driver for an RGB LED. Duty levels are sampled only at the
// frame boundary, so changes made mid-frame cannot glitch the pins.
module rgb_pwm_driver #(
   parameter int unsigned PRESCALE   = 4,
   parameter bit          ACTIVE_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] r,
   input  logic [7:0] g,
   input  logic [7:0] b,
   output logic       led_r,
   output logic       led_g,
   output logic       led_b,
   output logic       frame_start
);

   localparam int unsigned   PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
   localparam logic [7:0]    CNT_MAX = 8'd254;
   localparam logic [2:0]    LED_OFF = {3{ACTIVE_LOW}};

   logic [PW-1:0]   pre_q, pre_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [2:0][7:0] duty_q, duty_d;
   logic [2:0]      led_q, led_d;
   logic            frame_start_q, frame_start_d;

   logic [2:0][7:0] level;
   logic [2:0][7:0] eff_duty;
   logic            tick;
   logic            load;

   assign level = {b, g, r};
   assign tick  = en && (pre_q == PRE_MAX);
   assign load  = en && (pre_q == '0) && (cnt_q == 8'd0);

   always_comb begin
      pre_d         = pre_q;
      cnt_d         = cnt_q;
      duty_d        = duty_q;
      led_d         = LED_OFF;
      frame_start_d = 1'b0;
      eff_duty      = duty_q;

      if (!en) begin
         pre_d  = '0;
         cnt_d  = 8'd0;
         duty_d = '0;
      end else begin
         if (tick) begin
            pre_d = '0;
            cnt_d = (cnt_q == CNT_MAX) ? 8'd0 : cnt_q + 8'd1;
         end else begin
            pre_d = pre_q + PW'(1);
         end

         // The load cycle compares against the incoming level so the first
         // tick of a new frame already reflects the new duty.
         if (load) begin
            duty_d        = level;
            eff_duty      = level;
            frame_start_d = 1'b1;
         end

         for (int i = 0; i < 3; i++) begin
            led_d[i] = (cnt_q < eff_duty[i]) ^ ACTIVE_LOW;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q         <= '0;
         cnt_q         <= 8'd0;
         duty_q        <= '0;
         led_q         <= LED_OFF;
         frame_start_q <= 1'b0;
      end else begin
         pre_q         <= pre_d;
         cnt_q         <= cnt_d;
         duty_q        <= duty_d;
         led_q         <= led_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign led_r       = led_q[0];
   assign led_g       = led_q[1];
   assign led_b       = led_q[2];
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver: three instances (P=4 active-high, P=4 active-low,
// P=1 active-high) share inputs and are checked every cycle against a frame model.
module tb_rgb_pwm_driver;

   logic       clk;
   logic       rst;
   logic       en;
   logic [7:0] r, g, b;
   logic [2:0] lr, lg, lb, fs;

   int n_cmp = 0;
   int n_err = 0;
   bit cmp_on = 0;

   // model state, one slot per instance
   int m_t[3];
   int m_dr[3], m_dg[3], m_db[3];
   bit e_lr[3], e_lg[3], e_lb[3], e_fs[3];

   rgb_pwm_driver #(.PRESCALE(4), .ACTIVE_LOW(1'b0)) u_p4 (
      .clk(clk), .rst(rst), .en(en), .r(r), .g(g), .b(b),
      .led_r(lr[0]), .led_g(lg[0]), .led_b(lb[0]), .frame_start(fs[0]));

   rgb_pwm_driver #(.PRESCALE(4), .ACTIVE_LOW(1'b1)) u_p4_al (
      .clk(clk), .rst(rst), .en(en), .r(r), .g(g), .b(b),
      .led_r(lr[1]), .led_g(lg[1]), .led_b(lb[1]), .frame_start(fs[1]));

   rgb_pwm_driver #(.PRESCALE(1), .ACTIVE_LOW(1'b0)) u_p1 (
      .clk(clk), .rst(rst), .en(en), .r(r), .g(g), .b(b),
      .led_r(lr[2]), .led_g(lg[2]), .led_b(lb[2]), .frame_start(fs[2]));

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int p_of(input int i);
      return (i == 2) ? 1 : 4;
   endfunction

   function automatic bit al_of(input int i);
      return (i == 1);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Time since enable, modulo the frame length, gives the position in the frame;
   // a pin is lit while the elapsed whole ticks are below the frame's duty.
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         int k;
         int slot;
         if (rst || !en) begin
            m_t[i]  = 0;
            m_dr[i] = 0; m_dg[i] = 0; m_db[i] = 0;
            e_lr[i] = al_of(i); e_lg[i] = al_of(i); e_lb[i] = al_of(i);
            e_fs[i] = 1'b0;
         end else begin
            k = m_t[i] % (255 * p_of(i));
            if (k == 0) begin
               m_dr[i] = int'(r); m_dg[i] = int'(g); m_db[i] = int'(b);
            end
            slot    = k / p_of(i);
            e_lr[i] = (slot < m_dr[i]) ^ al_of(i);
            e_lg[i] = (slot < m_dg[i]) ^ al_of(i);
            e_lb[i] = (slot < m_db[i]) ^ al_of(i);
            e_fs[i] = (k == 0);
            m_t[i]++;
         end
      end
      cmp_on = 1'b1;
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (cmp_on) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("dut%0d led_r", i), int'(lr[i]), int'(e_lr[i]));
            chk($sformatf("dut%0d led_g", i), int'(lg[i]), int'(e_lg[i]));
            chk($sformatf("dut%0d led_b", i), int'(lb[i]), int'(e_lb[i]));
            chk($sformatf("dut%0d frame_start", i), int'(fs[i]), int'(e_fs[i]));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_fs(input int idx, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if (fs[idx]) begin
            ok = 1'b1;
            return;
         end
      end
      chk($sformatf("dut%0d frame_start timeout", idx), 0, 1);
   endtask

   // Measures one frame of instance 0 starting at its frame_start cycle.
   task automatic measure(input int chg_at, input logic [7:0] chg_val,
                          output int len, output int nr, output int ng, output int nb,
                          output bit g_first, output bit g_contig);
      bit ok;
      bit g_off_seen;
      len = 0; nr = 0; ng = 0; nb = 0;
      g_first = 1'b0; g_contig = 1'b1; g_off_seen = 1'b0;
      wait_fs(0, ok);
      if (!ok) return;
      g_first = lg[0];
      for (int i = 0; i < 3000; i++) begin
         if (i > 0 && fs[0]) return;
         nr += int'(lr[0]);
         nb += int'(lb[0]);
         if (lg[0]) begin
            ng++;
            if (g_off_seen) g_contig = 1'b0;
         end else begin
            g_off_seen = 1'b1;
         end
         len++;
         if (i == chg_at) g = chg_val;
         @(negedge clk);
      end
      chk("frame end timeout", 0, 1);
   endtask

   function automatic logic [7:0] pick_level();
      case ($urandom_range(0, 3))
         0:       return 8'd0;
         1:       return 8'd255;
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      int  len, nr, ng, nb;
      bit  gf, gc, ok;
      int  lit1, lit_at_fs;

      rst = 1'b1; en = 1'b1; r = 8'd0; g = 8'd0; b = 8'd0;

      // reset with en held high
      repeat (3) @(negedge clk);
      chk("reset led_r p4", int'(lr[0]), 0);
      chk("reset led_g active-low", int'(lg[1]), 1);
      chk("reset frame_start", int'(fs[0]), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("first frame_start after reset", int'(fs[0]), 1);

      // duty sweep
      r = 8'd0; g = 8'd128; b = 8'd255;
      measure(-1, 8'd0, len, nr, ng, nb, gf, gc);
      chk("sweep frame length", len, 1020);
      chk("sweep red lit", nr, 0);
      chk("sweep green lit", ng, 512);
      chk("sweep green lit at frame_start", int'(gf), 1);
      chk("sweep green contiguous", int'(gc), 1);
      chk("sweep blue lit", nb, 1020);

      // mid-frame change: current frame unaffected, following frame uses 10
      measure(300, 8'd10, len, nr, ng, nb, gf, gc);
      chk("midframe current green", ng, 512);
      measure(-1, 8'd0, len, nr, ng, nb, gf, gc);
      chk("midframe next green", ng, 40);
      chk("midframe next length", len, 1020);

      // disable while blue is lit
      wait_fs(0, ok);
      repeat (20) @(negedge clk);
      chk("blue lit before disable", int'(lb[0]), 1);
      en = 1'b0;
      @(negedge clk);
      chk("blue off after disable", int'(lb[0]), 0);
      chk("blue off after disable active-low", int'(lb[1]), 1);
      repeat (5) @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      chk("frame_start after re-enable", int'(fs[0]), 1);

      // PRESCALE = 1, r = 1
      r = 8'd1;
      wait_fs(2, ok);
      lit1 = 0;
      lit_at_fs = int'(lr[2]);
      for (int i = 0; i < 255; i++) begin
         lit1 += int'(lr[2]);
         @(negedge clk);
      end
      chk("p1 red lit clocks", lit1, 1);
      chk("p1 red lit at frame_start", lit_at_fs, 1);
      chk("p1 frame period", int'(fs[2]), 1);

      // reset priority over enable mid-frame
      repeat (100) @(negedge clk);
      rst = 1'b1; en = 1'b1;
      @(negedge clk);
      chk("rst prio led_b", int'(lb[0]), 0);
      chk("rst prio frame_start", int'(fs[0]), 0);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (fs[0] || fs[2]) chk("rst prio no pulse", 1, 0);
      end
      chk("rst prio led_r p1", int'(lr[2]), 0);
      rst = 1'b0;

      // randomized traffic, checked by the per-cycle model
      for (int seg = 0; seg < 8; seg++) begin
         int ncyc;
         r = pick_level(); g = pick_level(); b = pick_level();
         ncyc = $urandom_range(600, 1400);
         for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) begin
               case ($urandom_range(0, 2))
                  0:       r = pick_level();
                  1:       g = pick_level();
                  default: b = pick_level();
               endcase
            end
            en  = ($urandom_range(0, 299) != 0);
            rst = ($urandom_range(0, 999) == 0);
         end
         rst = 1'b0;
         en  = 1'b1;
      end

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
